// File: rtl/pkt139_fifo_reader.sv
// pkt139_fifo_reader: drains the 139-bit packet data FIFO and its companion
// packet-valid flag FIFO. Good packets are copied word-for-word downstream;
// packets flagged bad, with a bad head, or with no tail are flushed.
// Forward/drop/error events are counted in free-running wrapping counters.
// Read requests are decoded from the registered state and the FIFO status,
// so one word per clock can be drained from a show-ahead FIFO. Every
// downstream-facing output comes straight from a flop.
module pkt139_fifo_reader #(
    parameter logic [7:0] OUT_USEDW_MAX = 8'd160,
    parameter logic [7:0] MAX_WORDS     = 8'd100,
    parameter int         CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_data_empty,
    input  logic [138:0]     in_data,
    output logic             in_data_rdreq,
    input  logic             in_flag_empty,
    input  logic             in_flag,
    output logic             in_flag_rdreq,
    input  logic [7:0]       out_data_usedw,
    output logic             out_data_wrreq,
    output logic [138:0]     out_data,
    output logic             out_valid_wrreq,
    output logic             out_valid,
    output logic [CNT_W-1:0] cnt_fwd,
    output logic [CNT_W-1:0] cnt_drop,
    output logic [CNT_W-1:0] cnt_err
);

    // Downstream fill level at which an in-flight packet stops reading.
    localparam logic [7:0] USEDW_STALL = 8'd250;

    localparam logic [2:0] TYPE_HEAD = 3'b101;
    localparam logic [2:0] TYPE_TAIL = 3'b110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECIDE = 2'd1,
        FWD    = 2'd2,
        DROP   = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic               armed_reg;
    logic               flag_reg, flag_next;
    logic [7:0]         word_cnt_reg, word_cnt_next;
    logic               drop_counted_reg, drop_counted_next;
    logic [138:0]       out_data_reg, out_data_next;
    logic               out_data_wrreq_reg, out_data_wrreq_next;
    logic               out_valid_wrreq_reg, out_valid_wrreq_next;
    logic               out_valid_reg, out_valid_next;
    logic [CNT_W-1:0]   cnt_fwd_reg, cnt_fwd_next;
    logic [CNT_W-1:0]   cnt_drop_reg, cnt_drop_next;
    logic [CNT_W-1:0]   cnt_err_reg, cnt_err_next;
    logic               data_rdreq_c;
    logic               flag_rdreq_c;

    logic [2:0]         word_type;
    logic [7:0]         word_cnt_inc;

    assign word_type    = in_data[138:136];
    assign word_cnt_inc = word_cnt_reg + 8'd1;

    // State and datapath registers; reset abandons any packet in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg           <= IDLE;
            armed_reg           <= 1'b0;
            flag_reg            <= 1'b0;
            word_cnt_reg        <= 8'd0;
            drop_counted_reg    <= 1'b0;
            out_data_reg        <= '0;
            out_data_wrreq_reg  <= 1'b0;
            out_valid_wrreq_reg <= 1'b0;
            out_valid_reg       <= 1'b0;
            cnt_fwd_reg         <= '0;
            cnt_drop_reg        <= '0;
            cnt_err_reg         <= '0;
        end else begin
            state_reg           <= state_next;
            armed_reg           <= 1'b1;
            flag_reg            <= flag_next;
            word_cnt_reg        <= word_cnt_next;
            drop_counted_reg    <= drop_counted_next;
            out_data_reg        <= out_data_next;
            out_data_wrreq_reg  <= out_data_wrreq_next;
            out_valid_wrreq_reg <= out_valid_wrreq_next;
            out_valid_reg       <= out_valid_next;
            cnt_fwd_reg         <= cnt_fwd_next;
            cnt_drop_reg        <= cnt_drop_next;
            cnt_err_reg         <= cnt_err_next;
        end
    end

    // Next-state, FIFO pops, downstream writes and event counting.
    always_comb begin
        state_next           = state_reg;
        flag_next            = flag_reg;
        word_cnt_next        = word_cnt_reg;
        drop_counted_next    = drop_counted_reg;
        out_data_next        = out_data_reg;
        out_data_wrreq_next  = 1'b0;
        out_valid_wrreq_next = 1'b0;
        out_valid_next       = 1'b0;
        cnt_fwd_next         = cnt_fwd_reg;
        cnt_drop_next        = cnt_drop_reg;
        cnt_err_next         = cnt_err_reg;
        data_rdreq_c         = 1'b0;
        flag_rdreq_c         = 1'b0;

        case (state_reg)
            IDLE: begin
                // armed_reg keeps the pops low during and just after reset.
                if (armed_reg && !in_flag_empty && (out_data_usedw < OUT_USEDW_MAX)) begin
                    flag_rdreq_c = 1'b1;
                    flag_next    = in_flag;
                    state_next   = DECIDE;
                end
            end

            DECIDE: begin
                word_cnt_next = 8'd0;
                if (flag_reg) begin
                    drop_counted_next = 1'b0;
                    state_next        = FWD;
                end else begin
                    drop_counted_next = 1'b1;
                    state_next        = DROP;
                end
            end

            FWD: begin
                if (!in_data_empty && (out_data_usedw < USEDW_STALL)) begin
                    data_rdreq_c = 1'b1;
                    if ((word_cnt_reg == 8'd0) && (word_type != TYPE_HEAD)) begin
                        // Malformed start: nothing goes downstream.
                        cnt_err_next      = cnt_err_reg + 1'b1;
                        drop_counted_next = 1'b0;
                        state_next        = (word_type == TYPE_TAIL) ? IDLE : DROP;
                    end else if (word_type == TYPE_TAIL) begin
                        out_data_next        = in_data;
                        out_data_wrreq_next  = 1'b1;
                        out_valid_wrreq_next = 1'b1;
                        out_valid_next       = 1'b1;
                        cnt_fwd_next         = cnt_fwd_reg + 1'b1;
                        state_next           = IDLE;
                    end else if (word_cnt_inc == MAX_WORDS) begin
                        // Runaway packet: close it with a forced tail marked bad.
                        out_data_next        = {TYPE_TAIL, 4'd0, in_data[131:0]};
                        out_data_wrreq_next  = 1'b1;
                        out_valid_wrreq_next = 1'b1;
                        out_valid_next       = 1'b0;
                        cnt_err_next         = cnt_err_reg + 1'b1;
                        drop_counted_next    = 1'b0;
                        state_next           = DROP;
                    end else begin
                        out_data_next       = in_data;
                        out_data_wrreq_next = 1'b1;
                        word_cnt_next       = word_cnt_inc;
                    end
                end
            end

            DROP: begin
                if (!in_data_empty) begin
                    data_rdreq_c = 1'b1;
                    if (word_type == TYPE_TAIL) begin
                        if (drop_counted_reg) begin
                            cnt_drop_next = cnt_drop_reg + 1'b1;
                        end
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_data_rdreq   = data_rdreq_c;
    assign in_flag_rdreq   = flag_rdreq_c;
    assign out_data        = out_data_reg;
    assign out_data_wrreq  = out_data_wrreq_reg;
    assign out_valid_wrreq = out_valid_wrreq_reg;
    assign out_valid       = out_valid_reg;
    assign cnt_fwd         = cnt_fwd_reg;
    assign cnt_drop        = cnt_drop_reg;
    assign cnt_err         = cnt_err_reg;

endmodule

// File: tb/tb_pkt139_fifo_reader.sv
// Bench for pkt139_fifo_reader: show-ahead FIFO models feed the DUT,
// stimulus pushes expected downstream writes into a scoreboard queue and a
// separate monitor pops and compares on every out_data_wrreq.
module tb_pkt139_fifo_reader;

    localparam logic [2:0] T_HEAD = 3'b101;
    localparam logic [2:0] T_MID  = 3'b100;
    localparam logic [2:0] T_TAIL = 3'b110;

    logic         clk;
    logic         reset;
    logic         in_data_empty;
    logic [138:0] in_data;
    logic         in_data_rdreq;
    logic         in_flag_empty;
    logic         in_flag;
    logic         in_flag_rdreq;
    logic [7:0]   out_data_usedw;
    logic         out_data_wrreq;
    logic [138:0] out_data;
    logic         out_valid_wrreq;
    logic         out_valid;
    logic [31:0]  cnt_fwd;
    logic [31:0]  cnt_drop;
    logic [31:0]  cnt_err;

    typedef struct {
        logic [138:0] data;
        logic         last;
        logic         valid;
    } exp_t;

    logic [138:0] dq[$];
    logic         fq[$];
    exp_t         exp_q[$];

    int checks = 0;
    int errors = 0;
    int data_pops = 0;
    int exp_fwd = 0;
    int exp_drop = 0;
    int exp_err = 0;

    pkt139_fifo_reader dut (
        .clk             (clk),
        .reset           (reset),
        .in_data_empty   (in_data_empty),
        .in_data         (in_data),
        .in_data_rdreq   (in_data_rdreq),
        .in_flag_empty   (in_flag_empty),
        .in_flag         (in_flag),
        .in_flag_rdreq   (in_flag_rdreq),
        .out_data_usedw  (out_data_usedw),
        .out_data_wrreq  (out_data_wrreq),
        .out_data        (out_data),
        .out_valid_wrreq (out_valid_wrreq),
        .out_valid       (out_valid),
        .cnt_fwd         (cnt_fwd),
        .cnt_drop        (cnt_drop),
        .cnt_err         (cnt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [138:0] mk(input logic [2:0] t, input logic [3:0] nib,
                                        input logic [127:0] pl);
        return {t, nib, 4'h0, pl};
    endfunction

    // Show-ahead FIFO models: pops sampled mid-cycle, applied just after the edge.
    initial begin
        logic pd, pf;
        in_data_empty = 1'b1;
        in_flag_empty = 1'b1;
        in_data       = '0;
        in_flag       = 1'b0;
        forever begin
            @(negedge clk);
            pd = in_data_rdreq;
            pf = in_flag_rdreq;
            if (pd) begin
                checks++;
                if (in_data_empty) begin
                    errors++;
                    $display("FAIL data_rdreq_on_empty: rdreq=1 empty=%0b required no pop", in_data_empty);
                end
            end
            if (pf) begin
                checks++;
                if (in_flag_empty) begin
                    errors++;
                    $display("FAIL flag_rdreq_on_empty: rdreq=1 empty=%0b required no pop", in_flag_empty);
                end
            end
            @(posedge clk);
            #1;
            if (pd && dq.size() > 0) begin
                void'(dq.pop_front());
                data_pops++;
            end
            if (pf && fq.size() > 0) void'(fq.pop_front());
            in_data_empty = (dq.size() == 0);
            in_data       = (dq.size() > 0) ? dq[0] : '0;
            in_flag_empty = (fq.size() == 0);
            in_flag       = (fq.size() > 0) ? fq[0] : 1'b0;
        end
    end

    // Scoreboard monitor: one line per downstream write.
    always @(negedge clk) begin
        exp_t e;
        if (reset && out_data_wrreq) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got data=%h vw=%0b v=%0b required no write",
                         out_data, out_valid_wrreq, out_valid);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e.data || out_valid_wrreq !== e.last || out_valid !== e.valid) begin
                    errors++;
                    $display("FAIL write: got data=%h vw=%0b v=%0b required data=%h vw=%0b v=%0b",
                             out_data, out_valid_wrreq, out_valid, e.data, e.last, e.valid);
                end else begin
                    $display("write ok: data=%h vw=%0b v=%0b", out_data, out_valid_wrreq, out_valid);
                end
            end
        end else if (out_valid_wrreq) begin
            checks++;
            errors++;
            $display("FAIL stray_valid_wrreq: got vw=1 with data wrreq=%0b required 0", out_data_wrreq);
        end
    end

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [138:0] w, input logic exp_wr,
                             input logic last, input logic valid);
        exp_t e;
        dq.push_back(w);
        if (exp_wr) begin
            e.data  = w;
            e.last  = last;
            e.valid = valid;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_exp(input logic [138:0] w, input logic last, input logic valid);
        exp_t e;
        e.data  = w;
        e.last  = last;
        e.valid = valid;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((dq.size() != 0 || fq.size() != 0 || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: dq=%0d fq=%0d exp=%0d required all 0",
                     name, dq.size(), fq.size(), exp_q.size());
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end else begin
            $display("check %s ok: %0d", name, got);
        end
    endtask

    task automatic check_counters(input string name);
        check_val({name, "_cnt_fwd"}, cnt_fwd, exp_fwd);
        check_val({name, "_cnt_drop"}, cnt_drop, exp_drop);
        check_val({name, "_cnt_err"}, cnt_err, exp_err);
    endtask

    initial begin
        int pops0;
        int n;
        bit seen;
        reset          = 1'b0;
        out_data_usedw = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_outputs",
                  {24'd0, in_data_rdreq, in_flag_rdreq, out_data_wrreq, out_valid_wrreq, out_valid,
                   3'd0}, 32'd0);
        check_val("reset_out_data_lo", out_data[31:0], 32'd0);
        check_counters("reset");
        sync();
        reset = 1'b1;

        // 1: good 4-word packet
        sync();
        fq.push_back(1'b1);
        push_word(mk(T_HEAD, 4'h0, 128'h1001), 1'b1, 1'b0, 1'b0);
        push_word(mk(T_MID,  4'h0, 128'h1002), 1'b1, 1'b0, 1'b0);
        push_word(mk(T_MID,  4'h0, 128'h1003), 1'b1, 1'b0, 1'b0);
        push_word(mk(T_TAIL, 4'h4, 128'h1004), 1'b1, 1'b1, 1'b1);
        exp_fwd++;
        wait_idle("t1");
        check_counters("t1");

        // 2: flag 0 packet dropped, then a good packet
        sync();
        pops0 = data_pops;
        fq.push_back(1'b0);
        fq.push_back(1'b1);
        push_word(mk(T_HEAD, 4'h0, 128'h2001), 1'b0, 1'b0, 1'b0);
        push_word(mk(T_MID,  4'h0, 128'h2002), 1'b0, 1'b0, 1'b0);
        push_word(mk(T_TAIL, 4'h3, 128'h2003), 1'b0, 1'b0, 1'b0);
        push_word(mk(T_HEAD, 4'h0, 128'h2101), 1'b1, 1'b0, 1'b0);
        push_word(mk(T_TAIL, 4'h0, 128'h2102), 1'b1, 1'b1, 1'b1);
        exp_drop++;
        exp_fwd++;
        wait_idle("t2");
        check_val("t2_pops", data_pops - pops0, 5);
        check_counters("t2");

        // 3: bad head flushed to tail
        sync();
        fq.push_back(1'b1);
        push_word(mk(T_MID,  4'h0, 128'h3001), 1'b0, 1'b0, 1'b0);
        push_word(mk(T_MID,  4'h0, 128'h3002), 1'b0, 1'b0, 1'b0);
        push_word(mk(T_TAIL, 4'h1, 128'h3003), 1'b0, 1'b0, 1'b0);
        exp_err++;
        wait_idle("t3");
        check_counters("t3");

        // 4: 110 words, no tail among the first 100 -> forced tail at word 100
        sync();
        pops0 = data_pops;
        fq.push_back(1'b1);
        for (int i = 1; i <= 110; i++) begin
            logic [138:0] w;
            if (i == 1)        w = mk(T_HEAD, 4'h5, 128'(32'h4000 + i));
            else if (i == 110) w = mk(T_TAIL, 4'h0, 128'(32'h4000 + i));
            else               w = mk(T_MID,  4'h5, 128'(32'h4000 + i));
            dq.push_back(w);
            if (i < 100)       push_exp(w, 1'b0, 1'b0);
            else if (i == 100) push_exp(mk(T_TAIL, 4'h0, 128'(32'h4000 + i)), 1'b1, 1'b0);
        end
        exp_err++;
        wait_idle("t4");
        check_val("t4_pops", data_pops - pops0, 110);
        check_counters("t4");

        // 5: downstream full holds off packet start
        sync();
        out_data_usedw = 8'd200;
        fq.push_back(1'b1);
        push_word(mk(T_HEAD, 4'h0, 128'h5001), 1'b1, 1'b0, 1'b0);
        push_word(mk(T_TAIL, 4'h0, 128'h5002), 1'b1, 1'b1, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (in_flag_rdreq || in_data_rdreq) seen = 1'b1;
        end
        check_val("t5_held_rdreq", {31'd0, seen}, 32'd0);
        check_val("t5_flag_pending", fq.size(), 1);
        sync();
        out_data_usedw = 8'd10;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 2) begin
            @(negedge clk);
            n++;
            if (in_flag_rdreq) seen = 1'b1;
        end
        check_val("t5_start_after_release", {31'd0, seen}, 32'd1);
        exp_fwd++;
        wait_idle("t5");
        check_counters("t5");

        // 6: reset in the middle of FWD
        sync();
        out_data_usedw = 8'd0;
        fq.push_back(1'b1);
        push_word(mk(T_HEAD, 4'h0, 128'h6001), 1'b1, 1'b0, 1'b0);
        push_word(mk(T_MID,  4'h0, 128'h6002), 1'b1, 1'b0, 1'b0);
        push_word(mk(T_MID,  4'h0, 128'h6003), 1'b1, 1'b0, 1'b0);
        wait_idle("t6a");
        sync();
        reset = 1'b0;
        #1;
        check_val("t6_reset_ctl",
                  {27'd0, in_data_rdreq, in_flag_rdreq, out_data_wrreq, out_valid_wrreq, out_valid},
                  32'd0);
        check_val("t6_reset_out_data", {8'd0, out_data[138:128] ^ 11'd0, out_data[12:0]}, 32'd0);
        exp_fwd  = 0;
        exp_drop = 0;
        exp_err  = 0;
        check_counters("t6_reset");
        repeat (3) @(posedge clk);
        sync();
        reset = 1'b1;
        sync();
        fq.push_back(1'b1);
        push_word(mk(T_HEAD, 4'h0, 128'h7001), 1'b1, 1'b0, 1'b0);
        push_word(mk(T_MID,  4'h0, 128'h7002), 1'b1, 1'b0, 1'b0);
        push_word(mk(T_TAIL, 4'h8, 128'h7003), 1'b1, 1'b1, 1'b1);
        exp_fwd++;
        wait_idle("t6");
        check_counters("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
